uart_tx_ctrl: RTL
=================

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 8, data bits per frame.
REQ-002 SHALL have parameter: PRESCALE_WIDTH, 6, width of the clocks-per-bit value.
REQ-003 SHALL have port: CLK  input  1  system clock, rising edge.
REQ-004 SHALL have port: RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: i_data  input  DATA_WIDTH  parallel word to transmit.
REQ-006 SHALL have port: i_data_valid  input  1  transmit request.
REQ-007 SHALL have port: i_par_en  input  1  parity bit enable.
REQ-008 SHALL have port: i_par_typ  input  1  parity type, 0=even, 1=odd.
REQ-009 SHALL have port: i_prescale  input  PRESCALE_WIDTH  clocks per bit period (P).
REQ-010 SHALL have port: o_tx  output  1  serial line, registered.
REQ-011 SHALL have port: o_busy  output  1  frame in progress, registered.
REQ-012 SHALL have port: o_done  output  1  one-cycle frame-complete pulse, registered.

Function
REQ-013 SHALL transmit each frame in this order: start bit (0), DATA_WIDTH data bits LSB first, optional parity bit, one stop bit (1).
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-015 SHALL accept a request only in IDLE: a rising edge with i_data_valid=1 latches i_data, i_par_en, i_par_typ, i_prescale and moves to START.
REQ-016 SHALL make o_tx=0 and o_busy=1 in the clock cycle immediately after the accepting edge.
REQ-017 SHALL ignore i_data_valid in any non-IDLE state, with no queuing.
REQ-018 SHALL ignore changes on all inputs other than RST during a frame; only latched copies are used.
REQ-019 SHALL hold each bit on o_tx for exactly P clocks, using an internal tick counter that counts 0..P-1 and advances the bit/state on the P-1 terminal count.
REQ-020 SHALL treat a latched P=0 as P=1.
REQ-021 SHALL use a bit index of 0..DATA_WIDTH-1 in DATA; on the last data bit's terminal count, go to PARITY if the latched par_en=1, else go to STOP.
REQ-022 SHALL set the parity bit to the XOR of the latched data for even parity, and to its inverse for odd parity.
REQ-023 SHALL, on the STOP terminal count, go to IDLE; in that next cycle o_busy=0, o_tx=1, o_done=1 for exactly one cycle.
REQ-024 SHALL keep o_busy=1 for exactly (2+DATA_WIDTH+par_en)*P consecutive cycles per frame.
REQ-025 SHALL allow back-to-back frames: a request seen in the IDLE cycle carrying o_done is accepted, giving exactly one idle clock (o_tx=1) between frames.
REQ-026 SHALL hold o_tx=1 whenever in IDLE.
REQ-027 SHALL size the tick and bit counters so that P=2^PRESCALE_WIDTH-1 and DATA_WIDTH bits cause no overflow or wrap error.

Reset
REQ-028 SHALL, while RST=0, immediately force state=IDLE, all counters=0, o_tx=1, o_busy=0, o_done=0, independent of CLK.
REQ-029 SHALL, when reset asserts mid-frame, abort the frame with no o_done pulse; latched data is discarded.
REQ-030 SHALL accept a request at the first rising edge after RST deasserts if i_data_valid=1.

Verification
REQ-031 SHALL be verified with: P=4, i_data=0xA5, no parity -> o_tx bits 0,1,0,1,0,0,1,0,1,1, each 4 clocks; o_busy high 40 cycles; one o_done pulse.
REQ-032 SHALL be verified with: P=2, i_data=0x07, even then odd parity -> parity bit 1 then 0; 11 bits; o_busy high 22 cycles.
REQ-033 SHALL be verified with: i_data_valid held high, P=1, i_data 0x00 then 0xFF -> 10-cycle frames separated by exactly one o_tx=1 idle cycle; second frame carries 0xFF.
REQ-034 SHALL be verified with: i_data_valid pulse and i_data/i_prescale change mid-frame -> no effect on the current frame; no extra frame or o_done.
REQ-035 SHALL be verified with: RST low during DATA bit 3 -> o_tx=1 and o_busy=0 without a clock edge; no o_done; a new request after release sends a full frame.
REQ-036 SHALL be verified with: i_prescale=0 -> timing identical to P=1.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: serialises one parallel word per request as
// start, LSB-first data, optional parity and stop bits, each P clocks long.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     i_data,
  input  logic                      i_data_valid,
  input  logic                      i_par_en,
  input  logic                      i_par_typ,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  output logic                      o_tx,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                    state;
  logic [PRESCALE_WIDTH-1:0] tick_cnt;
  logic [PRESCALE_WIDTH-1:0] tick_last;
  logic [BIT_W-1:0]          bit_idx;
  logic [DATA_WIDTH-1:0]     shift;
  logic                      par_en;
  logic                      par_bit;
  logic                      tick_done;

  assign tick_done = (tick_cnt == tick_last);

  // tick_last holds P-1 (a zero prescale behaves as one clock per bit);
  // the data shifter always presents the next bit to send in shift[0].
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      tick_last <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      par_en    <= 1'b0;
      par_bit   <= 1'b0;
      o_tx      <= 1'b1;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          o_tx   <= 1'b1;
          o_busy <= 1'b0;
          if (i_data_valid) begin
            shift     <= i_data;
            par_en    <= i_par_en;
            par_bit   <= (^i_data) ^ i_par_typ;
            tick_last <= (i_prescale == '0) ? '0 : i_prescale - 1'b1;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            state     <= START;
            o_tx      <= 1'b0;
            o_busy    <= 1'b1;
          end
        end
        default: begin
          if (!tick_done) begin
            tick_cnt <= tick_cnt + 1'b1;
          end else begin
            tick_cnt <= '0;
            case (state)
              START: begin
                state   <= DATA;
                bit_idx <= '0;
                o_tx    <= shift[0];
                shift   <= shift >> 1;
              end
              DATA: begin
                if (bit_idx == LAST_BIT) begin
                  if (par_en) begin
                    state <= PARITY;
                    o_tx  <= par_bit;
                  end else begin
                    state <= STOP;
                    o_tx  <= 1'b1;
                  end
                end else begin
                  bit_idx <= bit_idx + 1'b1;
                  o_tx    <= shift[0];
                  shift   <= shift >> 1;
                end
              end
              PARITY: begin
                state <= STOP;
                o_tx  <= 1'b1;
              end
              STOP: begin
                state  <= IDLE;
                o_tx   <= 1'b1;
                o_busy <= 1'b0;
                o_done <= 1'b1;
              end
              default: begin
                state <= IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
